// File: rtl/key_debounce_pkg.sv
// Shared types and constants for the push-button debouncer.
package key_debounce_pkg;

  localparam int unsigned CntWidth              = 24;
  localparam int unsigned DefaultDebounceCycles = 1000000;

  typedef logic [CntWidth-1:0] cnt_t;

  typedef enum logic [1:0] {
    StIdle        = 2'd0,
    StPressWait   = 2'd1,
    StHeld        = 2'd2,
    StReleaseWait = 2'd3
  } key_state_e;

  // The debounced level is "down" once a press has been accepted and until the
  // release has been accepted.
  function automatic logic is_down(key_state_e st);
    return (st == StHeld) || (st == StReleaseWait);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// Single-key debouncer: two-flop synchronizer, four-state FSM, counter and
// registered level/pulse outputs.
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int unsigned DebounceCycles = DefaultDebounceCycles
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_ni,
  output logic pressed_o,
  output logic press_pulse_o,
  output logic release_pulse_o
);

  localparam cnt_t CntLast = cnt_t'(DebounceCycles - 1);

  logic [1:0] sync_q;
  logic       key_s;

  key_state_e state_q, state_d;
  cnt_t       cnt_q, cnt_d;

  logic pressed_q, pressed_d;
  logic press_pulse_q, press_pulse_d;
  logic release_pulse_q, release_pulse_d;

  // Synchronizer resets to the released level so reset never looks like a press.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], key_ni};
    end
  end

  assign key_s = sync_q[1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      pressed_q       <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      pressed_q       <= pressed_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (!key_s) begin
          state_d = StPressWait;
          cnt_d   = '0;
        end
      end
      StPressWait: begin
        if (key_s) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StHeld;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      StHeld: begin
        if (key_s) begin
          state_d = StReleaseWait;
          cnt_d   = '0;
        end
      end
      StReleaseWait: begin
        if (!key_s) begin
          state_d = StHeld;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the upcoming state so they change on the same
  // edge as the accepting transition.
  always_comb begin
    pressed_d       = is_down(state_d);
    press_pulse_d   = (state_q == StPressWait) && (state_d == StHeld);
    release_pulse_d = (state_q == StReleaseWait) && (state_d == StIdle);
  end

  assign pressed_o       = pressed_q;
  assign press_pulse_o   = press_pulse_q;
  assign release_pulse_o = release_pulse_q;

endmodule

// File: rtl/key_debounce.sv
// Debouncer for N_KEYS independent active-low push buttons.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int unsigned N_KEYS          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] pressed,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DebounceCycles (DEBOUNCE_CYCLES)
    ) u_ch (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .key_ni          (key_n[i]),
      .pressed_o       (pressed[i]),
      .press_pulse_o   (press_pulse[i]),
      .release_pulse_o (release_pulse[i])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce: directed table, corner sequences and a
// randomized run against a run-length reference model.
module tb_key_debounce;

  localparam int unsigned NKeys = 4;
  localparam int unsigned Deb   = 4;

  logic             clk;
  logic             rst_n;
  logic [NKeys-1:0] key_n;
  logic [NKeys-1:0] pressed;
  logic [NKeys-1:0] press_pulse;
  logic [NKeys-1:0] release_pulse;

  key_debounce #(
    .N_KEYS          (NKeys),
    .DEBOUNCE_CYCLES (Deb)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_n         (key_n),
    .pressed       (pressed),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a key's debounced level flips once the FSM-visible
  // (two-edge delayed) sample has disagreed with it on Deb+1 consecutive edges.
  logic [NKeys-1:0] hist[$];
  logic [NKeys-1:0] m_deb;
  logic [NKeys-1:0] m_pp;
  logic [NKeys-1:0] m_rp;
  int               m_run[NKeys];

  task automatic model_reset();
    m_deb = '0;
    m_pp  = '0;
    m_rp  = '0;
    for (int i = 0; i < NKeys; i++) m_run[i] = 0;
    hist.delete();
    hist.push_back('1);
    hist.push_back('1);
  endtask

  task automatic model_edge();
    logic [NKeys-1:0] ks;
    ks   = hist.pop_front();
    hist.push_back(key_n);
    m_pp = '0;
    m_rp = '0;
    for (int i = 0; i < NKeys; i++) begin
      if ((!ks[i]) != m_deb[i]) begin
        m_run[i]++;
        if (m_run[i] == Deb + 1) begin
          m_deb[i] = !m_deb[i];
          m_run[i] = 0;
          if (m_deb[i]) m_pp[i] = 1'b1;
          else          m_rp[i] = 1'b1;
        end
      end else begin
        m_run[i] = 0;
      end
    end
  endtask

  task automatic check(input string name, input logic [NKeys-1:0] act,
                       input logic [NKeys-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge; outputs compared to the model 1 time unit later.
  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check("pressed", pressed, m_deb);
    check("press_pulse", press_pulse, m_pp);
    check("release_pulse", release_pulse, m_rp);
    check("pulse_exclusive", press_pulse & release_pulse, '0);
  endtask

  task automatic assert_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_pressed", pressed, '0);
    check("rst_press_pulse", press_pulse, '0);
    check("rst_release_pulse", release_pulse, '0);
  endtask

  typedef struct {
    logic [NKeys-1:0] key_n;
    logic [NKeys-1:0] pressed;
    logic [NKeys-1:0] pp;
    logic [NKeys-1:0] rp;
  } vec_t;

  vec_t tbl[17];

  initial begin
    int cnt;
    logic [NKeys-1:0] k;

    // Clean press then release of key 0; entry j is clock edge j.
    tbl[0]  = '{4'b1110, 4'b0000, 4'b0000, 4'b0000};
    tbl[1]  = '{4'b1110, 4'b0000, 4'b0000, 4'b0000};
    tbl[2]  = '{4'b1110, 4'b0000, 4'b0000, 4'b0000};
    tbl[3]  = '{4'b1110, 4'b0000, 4'b0000, 4'b0000};
    tbl[4]  = '{4'b1110, 4'b0000, 4'b0000, 4'b0000};
    tbl[5]  = '{4'b1110, 4'b0000, 4'b0000, 4'b0000};
    tbl[6]  = '{4'b1110, 4'b0001, 4'b0001, 4'b0000};
    tbl[7]  = '{4'b1110, 4'b0001, 4'b0000, 4'b0000};
    tbl[8]  = '{4'b1110, 4'b0001, 4'b0000, 4'b0000};
    tbl[9]  = '{4'b1111, 4'b0001, 4'b0000, 4'b0000};
    tbl[10] = '{4'b1111, 4'b0001, 4'b0000, 4'b0000};
    tbl[11] = '{4'b1111, 4'b0001, 4'b0000, 4'b0000};
    tbl[12] = '{4'b1111, 4'b0001, 4'b0000, 4'b0000};
    tbl[13] = '{4'b1111, 4'b0001, 4'b0000, 4'b0000};
    tbl[14] = '{4'b1111, 4'b0001, 4'b0000, 4'b0000};
    tbl[15] = '{4'b1111, 4'b0000, 4'b0000, 4'b0001};
    tbl[16] = '{4'b1111, 4'b0000, 4'b0000, 4'b0000};

    key_n = '1;
    rst_n = 1'b1;
    model_reset();
    assert_reset();
    repeat (3) step();
    rst_n = 1'b1;
    repeat (3) step();

    for (int j = 0; j < 17; j++) begin
      key_n = tbl[j].key_n;
      step();
      check("tbl_pressed", pressed, tbl[j].pressed);
      check("tbl_press_pulse", press_pulse, tbl[j].pp);
      check("tbl_release_pulse", release_pulse, tbl[j].rp);
    end

    // Bounce on key 1, then a stable low.
    for (int j = 0; j < 10; j++) begin
      k      = '1;
      k[1]   = (j % 2 == 1);
      key_n  = k;
      step();
      check("bounce_no_pulse", {3'b000, press_pulse[1]}, 4'b0000);
    end
    key_n = 4'b1101;
    for (int j = 0; j < 10; j++) begin
      step();
      check("bounce_settle_pulse", {3'b000, press_pulse[1]}, {3'b000, j == 6});
    end

    // Release glitch on key 2 while held.
    key_n = 4'b1001;
    repeat (8) step();
    check("glitch_held", {3'b000, pressed[2]}, 4'b0001);
    key_n = 4'b1101;
    for (int j = 0; j < 12; j++) begin
      if (j == 2) key_n = 4'b1001;
      step();
      check("glitch_pressed", {3'b000, pressed[2]}, 4'b0001);
      check("glitch_no_release", {3'b000, release_pulse[2]}, 4'b0000);
    end

    // Simultaneous press and release of all keys.
    key_n = '1;
    repeat (10) step();
    key_n = '0;
    for (int j = 0; j < 10; j++) begin
      step();
      check("simul_press", press_pulse, (j == 6) ? 4'b1111 : 4'b0000);
    end
    key_n = '1;
    cnt   = 0;
    for (int j = 0; j < 12; j++) begin
      step();
      if (release_pulse == 4'b1111) cnt++;
      check("simul_release", release_pulse, (j == 6) ? 4'b1111 : 4'b0000);
    end
    check("simul_release_count", 4'(cnt), 4'd1);

    // Reset in the middle of key 3's debounce, key 0 already held.
    key_n = 4'b1110;
    repeat (8) step();
    key_n = 4'b0110;
    repeat (5) step();
    assert_reset();
    repeat (2) step();
    rst_n = 1'b1;
    for (int j = 0; j < 10; j++) begin
      step();
      check("post_rst_pulse3", {3'b000, press_pulse[3]}, {3'b000, j == 6});
      if (j < 6) check("post_rst_quiet", pressed | press_pulse | release_pulse, '0);
    end

    // Long hold on key 0.
    key_n = '1;
    repeat (10) step();
    key_n = 4'b1110;
    cnt   = 0;
    for (int j = 0; j < 1000; j++) begin
      step();
      if (press_pulse[0]) cnt++;
      if (j >= 6) check("long_hold_pressed", {3'b000, pressed[0]}, 4'b0001);
    end
    check("long_hold_one_pulse", 4'(cnt), 4'd1);
    key_n = '1;
    repeat (10) step();

    // Randomized traffic with occasional resets.
    for (int j = 0; j < 3000; j++) begin
      k = key_n;
      for (int i = 0; i < NKeys; i++) begin
        if ($urandom_range(7) == 0) k[i] = ~k[i];
      end
      key_n = k;
      if ($urandom_range(499) == 0) begin
        assert_reset();
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 The module SHALL have parameter N_KEYS, default 4, giving the number of independent push-button channels.
REQ-002 The module SHALL have parameter DEBOUNCE_CYCLES, default 1000000 (20 ms at 50 MHz), giving the stable-level time in clocks, legal range 2..2^24-1.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock, CLOCK_50 at the board top.
REQ-004 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The module SHALL have port key_n, input, N_KEYS bits: raw asynchronous board buttons, active-low (0 = pressed).
REQ-006 The module SHALL have port pressed, output, N_KEYS bits: debounced level, active-high.
REQ-007 The module SHALL have port press_pulse, output, N_KEYS bits: one-clock strobe on each debounced press, used as the counter step/load enable.
REQ-008 The module SHALL have port release_pulse, output, N_KEYS bits: one-clock strobe on each debounced release.

Function
REQ-009 Each channel SHALL pass key_n[i] through a two-flop synchronizer before any other use; key_s[i] denotes its output.
REQ-010 Each channel SHALL run one FSM with states IDLE, PRESS_WAIT, HELD and RELEASE_WAIT, plus a 24-bit counter cnt.
REQ-011 In IDLE, key_s=0 SHALL move the FSM to PRESS_WAIT with cnt=0; otherwise it SHALL stay in IDLE.
REQ-012 In PRESS_WAIT, key_s=1 SHALL return the FSM to IDLE with cnt=0 (bounce rejected, no pulse).
REQ-013 In PRESS_WAIT, key_s=0 with cnt<DEBOUNCE_CYCLES-1 SHALL increment cnt; key_s=0 with cnt==DEBOUNCE_CYCLES-1 SHALL move the FSM to HELD.
REQ-014 In HELD, key_s=1 SHALL move the FSM to RELEASE_WAIT with cnt=0; otherwise it SHALL stay in HELD.
REQ-015 RELEASE_WAIT SHALL mirror PRESS_WAIT with the key polarity inverted: key_s=0 returns the FSM to HELD, and reaching the count moves it to IDLE.
REQ-016 pressed[i] SHALL be registered and equal 1 exactly while the FSM is in HELD or RELEASE_WAIT.
REQ-017 press_pulse[i] SHALL be registered and high for exactly the one cycle following the PRESS_WAIT->HELD transition edge.
REQ-018 release_pulse[i] SHALL behave the same way for the RELEASE_WAIT->IDLE transition.
REQ-019 Latency SHALL be fixed: if edge 0 is the first clk edge that samples key_n low, and key_n then stays low, pressed and press_pulse SHALL rise at edge DEBOUNCE_CYCLES+2.
REQ-020 Release latency SHALL be identical to press latency.
REQ-021 Any opposite-level sample during a WAIT state SHALL restart the full DEBOUNCE_CYCLES interval on the next qualifying edge; there SHALL be no partial credit.
REQ-022 Channels SHALL be fully independent; simultaneous presses on several keys SHALL yield simultaneous pulses.
REQ-023 Holding a key indefinitely SHALL produce exactly one press_pulse (no auto-repeat), and cnt SHALL NOT wrap in HELD or IDLE.
REQ-024 press_pulse[i] and release_pulse[i] SHALL never be high in the same cycle.

Reset
REQ-025 On rst_n=0 the module SHALL immediately force: synchronizer flops to 1, FSM to IDLE, cnt to 0, and pressed, press_pulse and release_pulse to 0.
REQ-026 Reset asserted mid-debounce SHALL abort the debounce with no pulse.
REQ-027 A key held low through reset deassertion SHALL be treated as a new press, with press_pulse at edge DEBOUNCE_CYCLES+2 after the first post-reset sampling edge.
REQ-028 After rst_n deasserts, no output SHALL change before that edge DEBOUNCE_CYCLES+2.

Structure
REQ-029 The package key_debounce_pkg SHALL hold the FSM state encoding (2 bits: IDLE=0, PRESS_WAIT=1, HELD=2, RELEASE_WAIT=3), the default DEBOUNCE_CYCLES constant and the counter width constant of 24.
REQ-030 The design SHALL use one sub-module, key_debounce_ch (synchronizer, FSM, counter, and pulse registers for a single key), instantiated N_KEYS times by a generate loop.

Verification (DEBOUNCE_CYCLES=4, N_KEYS=4)
REQ-031 The bench SHALL cover a clean press: key_n[0] 1->0 held, edge 0 samples low -> pressed[0]=1 and press_pulse[0]=1 at edge 6 only, pulse low at edge 7.
REQ-032 The bench SHALL cover bounce rejection: key_n[1] toggling 0,1,0,1 each cycle for 10 cycles, then held 0 -> no pulse during the bounce, and press_pulse[1] 6 edges after the final stable low is first sampled.
REQ-033 The bench SHALL cover the release glitch: in HELD, key_n[2] high for 2 cycles then low again -> pressed[2] stays 1 and release_pulse[2] never fires.
REQ-034 The bench SHALL cover simultaneous keys: key_n 4'b1111->4'b0000 on the same edge -> press_pulse=4'b1111 in the same cycle, followed by exactly one release_pulse=4'b1111 after release.
REQ-035 The bench SHALL cover reset mid-operation: key_n[3] low, rst_n pulsed low at cnt=2 -> all outputs 0 immediately, and press_pulse[3] at edge 6 after rst_n rises with the key still low.
REQ-036 The bench SHALL cover the long hold: key_n[0] low for 1000 cycles -> exactly one press_pulse[0], and pressed[0] stays 1 throughout.
